// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 11-clock frame, ACK check, timeout.
// Accepts tx_start only in IDLE (no queueing); clk_oe rises the cycle after acceptance, data updates one cycle after each filtered device clock fall.

module ps2_line_filter #(
  parameter int FILTER_CYC = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic level_o
);
  localparam int CW = $clog2(FILTER_CYC + 1);

  logic [1:0]    sync_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      level_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync_q  <= {sync_q[0], raw_i};
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  // Counts consecutive samples that disagree with the accepted level.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CW'(FILTER_CYC - 1)) begin
        level_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  assign level_o = level_q;
endmodule

module ps2_host_tx #(
  parameter int CLK_HZ      = 50_000_000,
  parameter int INHIBIT_CYC = CLK_HZ / 10_000,
  parameter int TIMEOUT_CYC = CLK_HZ / 1000 * 15,
  parameter int FILTER_CYC  = 8
) (
  input  logic       CLK_50MHZ,
  input  logic       RST_N,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);
  localparam int INH_W = $clog2(INHIBIT_CYC + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_SHIFT,
    S_ACK,
    S_WAIT_REL
  } state_t;

  state_t           state_q, state_d;
  logic [9:0]       shreg_q, shreg_d;
  logic [3:0]       bitcnt_q, bitcnt_d;
  logic [INH_W-1:0] inh_q, inh_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic             dat_q, dat_d;
  logic             nack_q, nack_d;
  logic             clk_prev_q;

  logic clk_lvl, dat_lvl, clk_fall, timed, timeout;

  ps2_line_filter #(.FILTER_CYC(FILTER_CYC)) u_clk_filt (
    .clk     (CLK_50MHZ),
    .rst_n   (RST_N),
    .raw_i   (ps2_clk_in),
    .level_o (clk_lvl)
  );

  ps2_line_filter #(.FILTER_CYC(FILTER_CYC)) u_dat_filt (
    .clk     (CLK_50MHZ),
    .rst_n   (RST_N),
    .raw_i   (ps2_dat_in),
    .level_o (dat_lvl)
  );

  assign clk_fall = clk_prev_q & ~clk_lvl;
  assign timed    = (state_q == S_REQ) || (state_q == S_SHIFT) ||
                    (state_q == S_ACK) || (state_q == S_WAIT_REL);
  // A device edge in the terminal cycle still counts as progress.
  assign timeout  = timed && !clk_fall && (to_q == TO_W'(TIMEOUT_CYC));
  assign tx_busy  = (state_q != S_IDLE);

  always_ff @(posedge CLK_50MHZ or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= S_IDLE;
      shreg_q    <= '0;
      bitcnt_q   <= '0;
      inh_q      <= '0;
      to_q       <= '0;
      dat_q      <= 1'b0;
      nack_q     <= 1'b0;
      clk_prev_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bitcnt_q   <= bitcnt_d;
      inh_q      <= inh_d;
      to_q       <= to_d;
      dat_q      <= dat_d;
      nack_q     <= nack_d;
      clk_prev_q <= clk_lvl;
    end
  end

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bitcnt_d   = bitcnt_q;
    inh_d      = inh_q;
    to_d       = '0;
    dat_d      = dat_q;
    nack_d     = nack_q;
    ps2_clk_oe = 1'b0;
    ps2_dat_oe = 1'b0;
    tx_done    = 1'b0;
    tx_err     = 1'b0;

    if (timed && !clk_fall) begin
      to_d = to_q + TO_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (tx_start) begin
          shreg_d  = {1'b1, ~^tx_data, tx_data};
          bitcnt_d = '0;
          inh_d    = '0;
          dat_d    = 1'b0;
          nack_d   = 1'b0;
          state_d  = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        ps2_clk_oe = 1'b1;
        inh_d      = inh_q + INH_W'(1);
        if (inh_q == INH_W'(INHIBIT_CYC - 1)) begin
          ps2_dat_oe = 1'b1;
          state_d    = S_REQ;
        end
      end
      S_REQ, S_SHIFT: begin
        ps2_dat_oe = (state_q == S_REQ) ? 1'b1 : dat_q;
        if (clk_fall) begin
          dat_d    = ~shreg_q[0];
          shreg_d  = {1'b0, shreg_q[9:1]};
          bitcnt_d = bitcnt_q + 4'd1;
          state_d  = (bitcnt_q == 4'd9) ? S_ACK : S_SHIFT;
        end
      end
      S_ACK: begin
        ps2_dat_oe = dat_q;
        if (clk_fall) begin
          nack_d   = dat_lvl;
          bitcnt_d = bitcnt_q + 4'd1;
          state_d  = S_WAIT_REL;
        end
      end
      S_WAIT_REL: begin
        if (clk_lvl && dat_lvl) begin
          tx_done = 1'b1;
          tx_err  = nack_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (timeout) begin
      ps2_clk_oe = 1'b0;
      ps2_dat_oe = 1'b0;
      dat_d      = 1'b0;
      tx_done    = 1'b1;
      tx_err     = 1'b1;
      state_d    = S_IDLE;
    end
  end
endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed and randomized bench for ps2_host_tx with an open-drain PS/2 device model and frame reference model.
module tb_ps2_host_tx;
  localparam int INH  = 200;
  localparam int TO   = 4000;
  localparam int FILT = 8;
  localparam int HALF = 40;

  logic       clk;
  logic       RST_N;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy, tx_done, tx_err;
  logic       ps2_clk_oe, ps2_dat_oe;
  logic       dev_clk, dev_dat;
  logic       pin_clk, pin_dat;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int orphan_err = 0;
  int exp_done = 0;

  assign pin_clk = dev_clk & ~ps2_clk_oe;
  assign pin_dat = dev_dat & ~ps2_dat_oe;

  ps2_host_tx #(
    .CLK_HZ      (50_000_000),
    .INHIBIT_CYC (INH),
    .TIMEOUT_CYC (TO),
    .FILTER_CYC  (FILT)
  ) dut (
    .CLK_50MHZ  (clk),
    .RST_N      (RST_N),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .tx_err     (tx_err),
    .ps2_clk_in (pin_clk),
    .ps2_dat_in (pin_dat),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (tx_done) done_cnt <= done_cnt + 1;
    if (tx_err && !tx_done) orphan_err <= orphan_err + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected line levels seen by the device: start, data LSB first, odd parity, stop.
  function automatic logic [10:0] model_frame(input logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += (int'(d) >> i) & 1;
    return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, d, 1'b0};
  endfunction

  task automatic start_and_inhibit(input logic [7:0] d, input string tag);
    int n = 0;
    int first = -1;
    @(negedge clk);
    tx_data  = d;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    chk({tag, "_busy_acc"}, 32'(tx_busy), 32'd1);
    chk({tag, "_clkoe_acc"}, 32'(ps2_clk_oe), 32'd1);
    chk({tag, "_datoe_acc"}, 32'(ps2_dat_oe), 32'd0);
    while (ps2_clk_oe && n < INH + 50) begin
      if (ps2_dat_oe && first < 0) first = n;
      n++;
      @(negedge clk);
    end
    chk({tag, "_inhibit_len"}, 32'(n), 32'(INH));
    chk({tag, "_start_time"}, 32'(first), 32'(INH - 1));
    chk({tag, "_req_datoe"}, 32'(ps2_dat_oe), 32'd1);
  endtask

  task automatic dev_xfer(input bit ack, input bit glitch, input int inject_at,
                          input logic [7:0] inj, input int abort_at,
                          output logic [10:0] frame, output bit aborted);
    frame   = '0;
    aborted = 1'b0;
    frame[0] = pin_dat;
    repeat (20) @(negedge clk);
    for (int i = 1; i <= 11; i++) begin
      if (i == 11 && ack) begin
        dev_dat = 1'b0;
        repeat (4) @(negedge clk);
      end
      dev_clk = 1'b0;
      if (i == abort_at) begin
        repeat (HALF / 2) @(negedge clk);
        #3 RST_N = 1'b0;
        #1;
        chk("rst_async_clkoe", 32'(ps2_clk_oe), 32'd0);
        chk("rst_async_datoe", 32'(ps2_dat_oe), 32'd0);
        repeat (4) @(negedge clk);
        RST_N   = 1'b1;
        dev_clk = 1'b1;
        dev_dat = 1'b1;
        aborted = 1'b1;
        break;
      end
      if (glitch && i == 6) begin
        repeat (20) @(negedge clk);
        dev_clk = 1'b1;
        repeat (5) @(negedge clk);
        dev_clk = 1'b0;
        repeat (HALF - 25) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      dev_clk = 1'b1;
      if (i <= 10) frame[i] = pin_dat;
      if (i == inject_at) begin
        tx_data  = inj;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        repeat (HALF - 1) @(negedge clk);
      end else if (glitch && i == 4) begin
        repeat (15) @(negedge clk);
        dev_clk = 1'b0;
        repeat (5) @(negedge clk);
        dev_clk = 1'b1;
        repeat (HALF - 20) @(negedge clk);
      end else if (i < 11) begin
        repeat (HALF) @(negedge clk);
      end
    end
    if (!aborted) begin
      repeat (4) @(negedge clk);
      dev_dat = 1'b1;
    end
  endtask

  task automatic run_xfer(input logic [7:0] d, input bit ack, input bit glitch,
                          input int inject_at, input int abort_at, input string tag);
    logic [10:0] frame;
    bit aborted;
    int n = 0;
    start_and_inhibit(d, tag);
    dev_xfer(ack, glitch, inject_at, 8'(~d), abort_at, frame, aborted);
    if (!aborted) begin
      chk({tag, "_frame"}, 32'(frame), 32'(model_frame(d)));
      while (!tx_done && n < 500) begin
        @(negedge clk);
        n++;
      end
      chk({tag, "_done"}, 32'(tx_done), 32'd1);
      chk({tag, "_err"}, 32'(tx_err), ack ? 32'd0 : 32'd1);
      chk({tag, "_busy_at_done"}, 32'(tx_busy), 32'd1);
      exp_done++;
      @(negedge clk);
      chk({tag, "_busy_after"}, 32'(tx_busy), 32'd0);
    end
  endtask

  initial begin
    int n;
    logic [7:0] rd;
    bit rack, rgl;
    RST_N    = 1'b0;
    tx_start = 1'b0;
    tx_data  = 8'h00;
    dev_clk  = 1'b1;
    dev_dat  = 1'b1;
    #1;
    chk("rst_clkoe", 32'(ps2_clk_oe), 32'd0);
    chk("rst_datoe", 32'(ps2_dat_oe), 32'd0);
    chk("rst_busy", 32'(tx_busy), 32'd0);
    chk("rst_done", 32'(tx_done), 32'd0);
    chk("rst_err", 32'(tx_err), 32'd0);
    repeat (3) @(negedge clk);
    RST_N = 1'b1;
    repeat (20) @(negedge clk);

    run_xfer(8'hED, 1'b1, 1'b0, 0, 0, "ed");
    run_xfer(8'h01, 1'b1, 1'b0, 0, 0, "b01");
    run_xfer(8'hFF, 1'b1, 1'b0, 0, 0, "bff");
    run_xfer(8'h3C, 1'b0, 1'b0, 0, 0, "nack");

    start_and_inhibit(8'h12, "to");
    n = 0;
    while (!tx_done && n < TO + 100) begin
      @(negedge clk);
      n++;
    end
    chk("to_cycles", 32'(n), 32'(TO));
    chk("to_err", 32'(tx_err), 32'd1);
    chk("to_clkoe", 32'(ps2_clk_oe), 32'd0);
    chk("to_datoe", 32'(ps2_dat_oe), 32'd0);
    exp_done++;
    @(negedge clk);
    chk("to_idle_busy", 32'(tx_busy), 32'd0);

    run_xfer(8'hA5, 1'b1, 1'b0, 3, 0, "inject");
    repeat (30) @(negedge clk);
    chk("inject_no_requeue_busy", 32'(tx_busy), 32'd0);
    chk("inject_no_requeue_clkoe", 32'(ps2_clk_oe), 32'd0);

    run_xfer(8'h96, 1'b1, 1'b1, 0, 0, "glitch");

    run_xfer(8'h77, 1'b1, 1'b0, 0, 5, "abort");
    repeat (30) @(negedge clk);
    chk("abort_idle_busy", 32'(tx_busy), 32'd0);
    chk("abort_no_done", 32'(done_cnt), 32'(exp_done));
    run_xfer(8'h42, 1'b1, 1'b0, 0, 0, "post_rst");

    for (int k = 0; k < 4; k++) begin
      rd   = 8'($urandom_range(0, 255));
      rack = 1'($urandom_range(0, 1));
      rgl  = 1'($urandom_range(0, 1));
      run_xfer(rd, rack, rgl, 0, 0, $sformatf("rand%0d", k));
    end

    repeat (5) @(negedge clk);
    chk("done_total", 32'(done_cnt), 32'(exp_done));
    chk("orphan_err", 32'(orphan_err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
